// File: rtl/score_keeper.sv
// score_keeper: Pong game-flow controller.
// Owns both player scores and the IDLE/SERVE/PLAY/GAME_OVER state machine.
// Gates ball motion and requests ball re-centring with a serve direction.
// Ports:
//   i_clk          pixel clock
//   i_reset_n      synchronous active-low reset
//   i_frame_tick   one-cycle pulse per frame
//   i_start        start/restart button level; acts on its rising edge
//   i_pause        pause level; honoured in SERVE and PLAY only
//   i_miss_left    ball passed left edge (player 1 concedes)
//   i_miss_right   ball passed right edge (player 2 concedes)
//   o_score1/2     player scores, drive the digit font ROM addresses
//   o_ball_enable  ball may move
//   o_ball_reset   one-cycle re-centre request on every entry into SERVE
//   o_serve_dir    0 = toward left, 1 = toward right
//   o_game_over    high in GAME_OVER
//   o_winner       0 = player 1, 1 = player 2
//   o_state        IDLE=0, SERVE=1, PLAY=2, GAME_OVER=3
module score_keeper #(
   parameter logic [3:0] WIN_SCORE          = 4'd9,
   parameter logic [7:0] SERVE_DELAY_FRAMES = 8'd60
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_frame_tick,
   input  logic       i_start,
   input  logic       i_pause,
   input  logic       i_miss_left,
   input  logic       i_miss_right,
   output logic [3:0] o_score1,
   output logic [3:0] o_score2,
   output logic       o_ball_enable,
   output logic       o_ball_reset,
   output logic       o_serve_dir,
   output logic       o_game_over,
   output logic       o_winner,
   output logic [1:0] o_state
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      SERVE     = 2'd1,
      PLAY      = 2'd2,
      GAME_OVER = 2'd3
   } state_t;

   state_t     state, state_next;
   logic [3:0] score1, score1_next;
   logic [3:0] score2, score2_next;
   logic [7:0] count, count_next;
   logic       ball_enable, ball_enable_next;
   logic       ball_reset, ball_reset_next;
   logic       serve_dir, serve_dir_next;
   logic       game_over, game_over_next;
   logic       winner, winner_next;
   logic       start_prev;

   logic       start_event;
   logic [3:0] inc1, inc2;

   assign start_event = i_start & ~start_prev;
   assign inc1        = score1 + 4'd1;
   assign inc2        = score2 + 4'd1;

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         state       <= IDLE;
         score1      <= '0;
         score2      <= '0;
         count       <= '0;
         ball_enable <= 1'b0;
         ball_reset  <= 1'b0;
         serve_dir   <= 1'b0;
         game_over   <= 1'b0;
         winner      <= 1'b0;
         start_prev  <= 1'b0;
      end else begin
         state       <= state_next;
         score1      <= score1_next;
         score2      <= score2_next;
         count       <= count_next;
         ball_enable <= ball_enable_next;
         ball_reset  <= ball_reset_next;
         serve_dir   <= serve_dir_next;
         game_over   <= game_over_next;
         winner      <= winner_next;
         start_prev  <= i_start;
      end
   end

   always_comb begin
      state_next       = state;
      score1_next      = score1;
      score2_next      = score2;
      count_next       = count;
      ball_enable_next = 1'b0;
      ball_reset_next  = 1'b0;
      serve_dir_next   = serve_dir;
      game_over_next   = game_over;
      winner_next      = winner;

      case (state)
         IDLE, GAME_OVER: begin
            // Start (or restart) always begins a fresh game with a left serve.
            if (start_event) begin
               score1_next     = '0;
               score2_next     = '0;
               game_over_next  = 1'b0;
               serve_dir_next  = 1'b0;
               count_next      = SERVE_DELAY_FRAMES;
               ball_reset_next = 1'b1;
               state_next      = SERVE;
            end
         end

         SERVE: begin
            if (count == '0) begin
               ball_enable_next = 1'b1;
               state_next       = PLAY;
            end else if (i_frame_tick && !i_pause) begin
               count_next = count - 8'd1;
            end
         end

         PLAY: begin
            ball_enable_next = ~i_pause;
            if (!i_pause && (i_miss_left || i_miss_right)) begin
               // Default outcome is a re-serve; the single-miss branches
               // below override it when the new score wins the game.
               ball_enable_next = 1'b0;
               ball_reset_next  = 1'b1;
               count_next       = SERVE_DELAY_FRAMES;
               state_next       = SERVE;
               if (i_miss_left && !i_miss_right) begin
                  score2_next    = inc2;
                  serve_dir_next = 1'b0;
                  if (inc2 == WIN_SCORE) begin
                     ball_reset_next = 1'b0;
                     game_over_next  = 1'b1;
                     winner_next     = 1'b1;
                     state_next      = GAME_OVER;
                  end
               end else if (i_miss_right && !i_miss_left) begin
                  score1_next    = inc1;
                  serve_dir_next = 1'b1;
                  if (inc1 == WIN_SCORE) begin
                     ball_reset_next = 1'b0;
                     game_over_next  = 1'b1;
                     winner_next     = 1'b0;
                     state_next      = GAME_OVER;
                  end
               end
            end
         end

         default: state_next = IDLE;
      endcase
   end

   assign o_score1      = score1;
   assign o_score2      = score2;
   assign o_ball_enable = ball_enable;
   assign o_ball_reset  = ball_reset;
   assign o_serve_dir   = serve_dir;
   assign o_game_over   = game_over;
   assign o_winner      = winner;
   assign o_state       = state;

endmodule

// File: tb/tb_score_keeper.sv
// tb_score_keeper: self-checking bench for score_keeper.
// Every expected serve (scores and direction at the o_ball_reset pulse) is
// queued when the triggering stimulus is driven and compared when the pulse
// appears; state, enable and game-over behaviour are checked inline.
module tb_score_keeper;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       frame_tick;
   logic       start;
   logic       pause;
   logic       miss_left;
   logic       miss_right;
   logic [3:0] score1;
   logic [3:0] score2;
   logic       ball_enable;
   logic       ball_reset;
   logic       serve_dir;
   logic       game_over;
   logic       winner;
   logic [1:0] state;

   always #5 clk = ~clk;

   score_keeper #(
      .WIN_SCORE          (4'd9),
      .SERVE_DELAY_FRAMES (8'd60)
   ) dut (
      .i_clk         (clk),
      .i_reset_n     (rst_n),
      .i_frame_tick  (frame_tick),
      .i_start       (start),
      .i_pause       (pause),
      .i_miss_left   (miss_left),
      .i_miss_right  (miss_right),
      .o_score1      (score1),
      .o_score2      (score2),
      .o_ball_enable (ball_enable),
      .o_ball_reset  (ball_reset),
      .o_serve_dir   (serve_dir),
      .o_game_over   (game_over),
      .o_winner      (winner),
      .o_state       (state)
   );

   typedef struct {
      logic [3:0] s1;
      logic [3:0] s2;
      logic       dir;
   } serve_t;

   serve_t     sb[$];
   int         errors = 0;
   int         checks = 0;
   logic [3:0] m_s1;
   logic [3:0] m_s2;
   logic       m_dir;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   task automatic cyc(input int unsigned n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic frame(input int unsigned n);
      repeat (n) begin
         frame_tick = 1'b1;
         cyc(1);
         frame_tick = 1'b0;
      end
   endtask

   task automatic push_serve();
      serve_t e;
      e.s1  = m_s1;
      e.s2  = m_s2;
      e.dir = m_dir;
      sb.push_back(e);
   endtask

   task automatic miss(input logic l, input logic r);
      miss_left  = l;
      miss_right = r;
      cyc(1);
      miss_left  = 1'b0;
      miss_right = 1'b0;
   endtask

   // After n counted ticks the ball must still be held; one cycle later it plays.
   task automatic serve_to_play(input int unsigned n);
      frame(n);
      check("serve_hold_state", state, 1);
      check("serve_hold_enable", ball_enable, 0);
      cyc(1);
      check("play_state", state, 2);
      check("play_enable", ball_enable, 1);
   endtask

   task automatic check_reset_values();
      check("rst_state", state, 0);
      check("rst_score1", score1, 0);
      check("rst_score2", score2, 0);
      check("rst_enable", ball_enable, 0);
      check("rst_ball_reset", ball_reset, 0);
      check("rst_serve_dir", serve_dir, 0);
      check("rst_game_over", game_over, 0);
      check("rst_winner", winner, 0);
   endtask

   // Scoreboard consumer: one queued expectation per o_ball_reset cycle.
   always @(negedge clk) begin
      if (rst_n && ball_reset) begin
         check("serve_expected", (sb.size() > 0), 1);
         if (sb.size() > 0) begin
            serve_t e;
            e = sb.pop_front();
            check("serve_score1", score1, e.s1);
            check("serve_score2", score2, e.s2);
            check("serve_dir", serve_dir, e.dir);
            check("serve_state", state, 1);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
      $fatal(1, "timeout");
   end

   initial begin
      rst_n      = 1'b0;
      frame_tick = 1'b0;
      start      = 1'b0;
      pause      = 1'b0;
      miss_left  = 1'b0;
      miss_right = 1'b0;
      cyc(2);
      rst_n = 1'b1;
      check_reset_values();

      // Start press, 60-tick serve delay
      m_s1 = 4'd0; m_s2 = 4'd0; m_dir = 1'b0;
      push_serve();
      start = 1'b1;
      cyc(1);
      check("start_state", state, 1);
      start = 1'b0;
      serve_to_play(60);

      // Left miss scores for player 2; miss during SERVE ignored
      m_s2 = 4'd1; m_dir = 1'b0;
      push_serve();
      miss(1'b1, 1'b0);
      check("missl_state", state, 1);
      check("missl_score2", score2, 1);
      check("missl_enable", ball_enable, 0);
      miss(1'b0, 1'b1);
      check("serve_miss_ignored", score1, 0);
      serve_to_play(60);

      // Right miss then a draw keeping serve_dir = 1
      m_s1 = 4'd1; m_dir = 1'b1;
      push_serve();
      miss(1'b0, 1'b1);
      check("missr_score1", score1, 1);
      serve_to_play(60);
      push_serve();
      miss(1'b1, 1'b1);
      check("draw_state", state, 1);
      check("draw_score1", score1, 1);
      check("draw_score2", score2, 1);

      // Pause in SERVE freezes the countdown for 10 ticks
      frame(20);
      pause = 1'b1;
      frame(10);
      check("pause_serve_state", state, 1);
      pause = 1'b0;
      serve_to_play(40);

      // Pause in PLAY drops enable and masks misses
      pause = 1'b1;
      cyc(1);
      check("pause_play_enable", ball_enable, 0);
      miss(1'b1, 1'b0);
      check("pause_miss_state", state, 2);
      check("pause_miss_score2", score2, 1);
      pause = 1'b0;
      cyc(1);
      check("unpause_enable", ball_enable, 1);

      // Player 1 climbs to 8, then wins with start already held
      while (m_s1 < 4'd8) begin
         m_s1 = m_s1 + 4'd1;
         m_dir = 1'b1;
         push_serve();
         miss(1'b0, 1'b1);
         serve_to_play(60);
      end
      check("pre_win_score1", score1, 8);
      start = 1'b1;
      cyc(2);
      miss(1'b0, 1'b1);
      check("win_state", state, 3);
      check("win_game_over", game_over, 1);
      check("win_winner", winner, 0);
      check("win_score1", score1, 9);
      check("win_score2", score2, 1);
      check("win_enable", ball_enable, 0);
      cyc(20);
      check("held_start_state", state, 3);
      check("held_start_score1", score1, 9);
      start = 1'b0;
      cyc(2);
      m_s1 = 4'd0; m_s2 = 4'd0; m_dir = 1'b0;
      push_serve();
      start = 1'b1;
      cyc(1);
      start = 1'b0;
      check("restart_state", state, 1);
      check("restart_game_over", game_over, 0);
      check("restart_score1", score1, 0);
      check("restart_score2", score2, 0);
      serve_to_play(60);

      // Reach 3/5 then reset mid-play
      for (int unsigned i = 0; i < 8; i++) begin
         if (i < 3) begin
            m_s1 = m_s1 + 4'd1;
            m_dir = 1'b1;
            push_serve();
            miss(1'b0, 1'b1);
         end else begin
            m_s2 = m_s2 + 4'd1;
            m_dir = 1'b0;
            push_serve();
            miss(1'b1, 1'b0);
         end
         serve_to_play(60);
      end
      check("mid_score1", score1, 3);
      check("mid_score2", score2, 5);
      rst_n = 1'b0;
      cyc(1);
      rst_n = 1'b1;
      check_reset_values();
      cyc(3);
      check("post_rst_state", state, 0);

      check("scoreboard_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
